exe_issue_ctrl: RTL and testbench

//  Execute-stage sequencer between decode and the ALU. Latches one decoded instruction,

---
 rtl/exe_issue_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_exe_issue_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_issue_ctrl.sv
// rtl/exe_issue_ctrl.sv - execute-stage issue sequencer between decode and the ALU
// Optional performance counters are enabled by defining EXE_PERF_EN.
module exe_issue_ctrl #(
  parameter int         MUL_LAT  = 3,
  parameter logic [9:0] OPC_IMUL = 10'h0F7
`ifdef EXE_PERF_EN
  , parameter int       CNT_W    = 32
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [9:0]  dec_opcode,
  input  logic [63:0] dec_oprd1,
  input  logic [63:0] dec_oprd2,
  input  logic [63:0] dec_oprd3,
  input  logic [63:0] dec_next_rip,
  output logic        alu_enable,
  output logic [9:0]  alu_opcode,
  output logic [63:0] alu_oprd1,
  output logic [63:0] alu_oprd2,
  output logic [63:0] alu_oprd3,
  output logic [63:0] alu_next_rip,
  input  logic        mem_blocked,
  input  logic        alu_branch,
  input  logic [63:0] alu_branch_rip,
  output logic        redirect,
  output logic [63:0] redirect_rip,
  output logic        flush_dec,
  output logic        busy
`ifdef EXE_PERF_EN
  , output logic [CNT_W-1:0] perf_issued,
  output logic [CNT_W-1:0] perf_stall
`endif
);

  localparam int CW = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_MULTI   = 2'd2,
    S_WAIT_BR = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_complete;
  logic          w_transfer;
  logic          w_is_imul;
  logic          w_is_branch;

  logic [9:0]    r_opcode;
  logic [63:0]   r_oprd1;
  logic [63:0]   r_oprd2;
  logic [63:0]   r_oprd3;
  logic [63:0]   r_next_rip;

  // The ALU always sees the hold registers; enable qualifies them.
  assign alu_opcode   = r_opcode;
  assign alu_oprd1    = r_oprd1;
  assign alu_oprd2    = r_oprd2;
  assign alu_oprd3    = r_oprd3;
  assign alu_next_rip = r_next_rip;

  // Classify the held opcode: multi-cycle multiply and the three branch groups.
  always_comb begin
    w_is_imul   = (r_opcode == OPC_IMUL);
    w_is_branch = (r_opcode[9:4] == 6'b00_0111) ||
                  (r_opcode == 10'h0EB) ||
                  (r_opcode[9:4] == 6'b01_1000);
  end

  // Next state, completion, handshake and per-state outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_complete   = 1'b0;
    alu_enable   = 1'b0;
    redirect     = 1'b0;
    redirect_rip = 64'd0;
    flush_dec    = 1'b0;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_IDLE;
      end
      S_ISSUE: begin
        alu_enable = 1'b1;
        if (!mem_blocked) begin
          if (w_is_imul && (MUL_LAT > 1)) begin
            w_state_nxt = S_MULTI;
            w_cnt_nxt   = CW'(MUL_LAT - 1);
          end else if (w_is_branch) begin
            w_state_nxt = S_WAIT_BR;
          end else begin
            w_complete  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_MULTI: begin
        alu_enable = 1'b1;
        if (!mem_blocked) begin
          if (r_cnt == CW'(1)) begin
            w_complete  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - CW'(1);
          end
        end
      end
      S_WAIT_BR: begin
        // One cycle only: the ALU's registered branch flag is valid now.
        redirect     = alu_branch;
        redirect_rip = alu_branch_rip;
        flush_dec    = alu_branch;
        w_state_nxt  = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Nothing is accepted while reset is held so every output reads 0.
    dec_ready  = rst_n && ((r_state == S_IDLE) || w_complete);
    w_transfer = dec_valid && dec_ready;
    if (w_transfer) begin
      w_state_nxt = S_ISSUE;
    end
  end

  // State and multiply countdown registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Latch the decoded instruction on each accepted transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_opcode   <= 10'd0;
      r_oprd1    <= 64'd0;
      r_oprd2    <= 64'd0;
      r_oprd3    <= 64'd0;
      r_next_rip <= 64'd0;
    end else if (w_transfer) begin
      r_opcode   <= dec_opcode;
      r_oprd1    <= dec_oprd1;
      r_oprd2    <= dec_oprd2;
      r_oprd3    <= dec_oprd3;
      r_next_rip <= dec_next_rip;
    end
  end

`ifdef EXE_PERF_EN
  logic [CNT_W-1:0] r_perf_issued;
  logic [CNT_W-1:0] r_perf_stall;

  assign perf_issued = r_perf_issued;
  assign perf_stall  = r_perf_stall;

  // Free-running wrap-around counters of accepted instructions and stalled ALU cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_issued <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_transfer) begin
        r_perf_issued <= r_perf_issued + 1'b1;
      end
      if (alu_enable && mem_blocked) begin
        r_perf_stall <= r_perf_stall + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_exe_issue_ctrl.sv
// tb/tb_exe_issue_ctrl.sv - self-checking bench for exe_issue_ctrl
module tb_exe_issue_ctrl;

  localparam int         MUL_LAT  = 3;
  localparam logic [9:0] OPC_IMUL = 10'h0F7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid;
  logic        dec_ready;
  logic [9:0]  dec_opcode;
  logic [63:0] dec_oprd1, dec_oprd2, dec_oprd3, dec_next_rip;
  logic        alu_enable;
  logic [9:0]  alu_opcode;
  logic [63:0] alu_oprd1, alu_oprd2, alu_oprd3, alu_next_rip;
  logic        mem_blocked;
  logic        alu_branch;
  logic [63:0] alu_branch_rip;
  logic        redirect;
  logic [63:0] redirect_rip;
  logic        flush_dec;
  logic        busy;
`ifdef EXE_PERF_EN
  logic [31:0] perf_issued, perf_stall;
`endif

  exe_issue_ctrl #(.MUL_LAT(MUL_LAT), .OPC_IMUL(OPC_IMUL)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_opcode(dec_opcode),
    .dec_oprd1(dec_oprd1), .dec_oprd2(dec_oprd2), .dec_oprd3(dec_oprd3),
    .dec_next_rip(dec_next_rip),
    .alu_enable(alu_enable), .alu_opcode(alu_opcode),
    .alu_oprd1(alu_oprd1), .alu_oprd2(alu_oprd2), .alu_oprd3(alu_oprd3),
    .alu_next_rip(alu_next_rip),
    .mem_blocked(mem_blocked), .alu_branch(alu_branch), .alu_branch_rip(alu_branch_rip),
    .redirect(redirect), .redirect_rip(redirect_rip), .flush_dec(flush_dec), .busy(busy)
`ifdef EXE_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        v;
    logic [9:0]  op;
    logic [63:0] o1;
    logic [63:0] o2;
    logic        mb;
    logic        br;
    logic        e_en;
    logic        e_rdy;
    logic        e_busy;
    logic        e_red;
    logic [63:0] e_o1;
    logic [63:0] e_o2;
  } vec_t;

  function automatic vec_t mk(logic v, logic [9:0] op, logic [63:0] o1, logic [63:0] o2,
                              logic mb, logic br, logic en, logic rdy, logic bsy, logic red,
                              logic [63:0] eo1, logic [63:0] eo2);
    vec_t t;
    t.v = v; t.op = op; t.o1 = o1; t.o2 = o2; t.mb = mb; t.br = br;
    t.e_en = en; t.e_rdy = rdy; t.e_busy = bsy; t.e_red = red; t.e_o1 = eo1; t.e_o2 = eo2;
    return t;
  endfunction

  // Reference classification straight from the opcode groups.
  function automatic bit ref_is_branch(logic [9:0] op);
    int unsigned u;
    u = op;
    return ((u >> 4) == 'h07) || (u == 'h0EB) || ((u >> 4) == 'h18);
  endfunction

  vec_t vec[$];

  // Work-unit model: an instruction in execute needs 'left' unblocked ALU cycles,
  // then either retires or spends one cycle waiting for the branch result.
  bit          m_have, m_brw, m_isbr;
  int          m_left;
  logic [9:0]  m_op;
  logic [63:0] m_o1, m_o2, m_o3, m_rip;
  int          m_issued, m_stall;

  initial begin
    vec_t t;
    bit   e_en, e_rdy, e_busy, e_red, xfer;
    int   tab_iss, tab_stall;
    logic [9:0] ops [0:5];

    // cycle-by-cycle vectors: inputs for the cycle, outputs expected in that cycle
    // 1: single ADD
    vec.push_back(mk(1, 10'h001,  5,  7, 0, 0,  0, 1, 0, 0,  0, 0));
    vec.push_back(mk(0, 10'h001,  0,  0, 0, 0,  1, 1, 1, 0,  5, 7));
    vec.push_back(mk(0, 10'h001,  0,  0, 0, 0,  0, 1, 0, 0,  5, 7));
    // 2: three back-to-back ADDs
    vec.push_back(mk(1, 10'h001,  1,  0, 0, 0,  0, 1, 0, 0,  5, 7));
    vec.push_back(mk(1, 10'h001,  2,  0, 0, 0,  1, 1, 1, 0,  1, 0));
    vec.push_back(mk(1, 10'h001,  3,  0, 0, 0,  1, 1, 1, 0,  2, 0));
    vec.push_back(mk(0, 10'h001,  0,  0, 0, 0,  1, 1, 1, 0,  3, 0));
    vec.push_back(mk(0, 10'h001,  0,  0, 0, 0,  0, 1, 0, 0,  3, 0));
    // 3: IMUL with a following ADD waiting at decode
    vec.push_back(mk(1, 10'h0F7,  9,  0, 0, 0,  0, 1, 0, 0,  3, 0));
    vec.push_back(mk(1, 10'h001, 10,  0, 0, 0,  1, 0, 1, 0,  9, 0));
    vec.push_back(mk(1, 10'h001, 10,  0, 0, 0,  1, 0, 1, 0,  9, 0));
    vec.push_back(mk(1, 10'h001, 10,  0, 0, 0,  1, 1, 1, 0,  9, 0));
    vec.push_back(mk(0, 10'h001,  0,  0, 0, 0,  1, 1, 1, 0, 10, 0));
    vec.push_back(mk(0, 10'h001,  0,  0, 0, 0,  0, 1, 0, 0, 10, 0));
    // 4: ADD stalled by mem_blocked for two cycles
    vec.push_back(mk(1, 10'h001, 11,  0, 0, 0,  0, 1, 0, 0, 10, 0));
    vec.push_back(mk(1, 10'h001, 12,  0, 1, 0,  1, 0, 1, 0, 11, 0));
    vec.push_back(mk(1, 10'h001, 12,  0, 1, 0,  1, 0, 1, 0, 11, 0));
    vec.push_back(mk(0, 10'h001,  0,  0, 0, 0,  1, 1, 1, 0, 11, 0));
    vec.push_back(mk(0, 10'h001,  0,  0, 0, 0,  0, 1, 0, 0, 11, 0));
    // 5: taken JMP, decode offering during the redirect cycle
    vec.push_back(mk(1, 10'h0EB, 13,  0, 0, 0,  0, 1, 0, 0, 11, 0));
    vec.push_back(mk(1, 10'h001, 14,  0, 0, 0,  1, 0, 1, 0, 13, 0));
    vec.push_back(mk(1, 10'h001, 14,  0, 0, 1,  0, 0, 1, 1, 13, 0));
    vec.push_back(mk(0, 10'h001,  0,  0, 0, 0,  0, 1, 0, 0, 13, 0));
    // not-taken branch from the 07x group
    vec.push_back(mk(1, 10'h075, 15,  0, 0, 0,  0, 1, 0, 0, 13, 0));
    vec.push_back(mk(0, 10'h001,  0,  0, 0, 0,  1, 0, 1, 0, 15, 0));
    vec.push_back(mk(0, 10'h001,  0,  0, 0, 0,  0, 0, 1, 0, 15, 0));
    vec.push_back(mk(0, 10'h001,  0,  0, 0, 0,  0, 1, 0, 0, 15, 0));
    // 18x branch accepted while mem_blocked in IDLE, blocked in ISSUE, ignored in WAIT_BR
    vec.push_back(mk(1, 10'h185, 16,  0, 1, 0,  0, 1, 0, 0, 15, 0));
    vec.push_back(mk(0, 10'h001,  0,  0, 1, 0,  1, 0, 1, 0, 16, 0));
    vec.push_back(mk(0, 10'h001,  0,  0, 0, 0,  1, 0, 1, 0, 16, 0));
    vec.push_back(mk(0, 10'h001,  0,  0, 1, 1,  0, 0, 1, 1, 16, 0));
    vec.push_back(mk(0, 10'h001,  0,  0, 0, 0,  0, 1, 0, 0, 16, 0));

    rst_n = 1'b0; dec_valid = 0; dec_opcode = 0; dec_oprd1 = 0; dec_oprd2 = 0;
    dec_oprd3 = 0; dec_next_rip = 0; mem_blocked = 0; alu_branch = 0; alu_branch_rip = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_en", alu_enable, 0);
    chk("rst_ready", dec_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_redirect", redirect, 0);
    chk("rst_flush", flush_dec, 0);
    chk("rst_oprd1", alu_oprd1, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("idle_ready", dec_ready, 1);

    tab_iss = 0; tab_stall = 0;
    foreach (vec[i]) begin
      t = vec[i];
      @(negedge clk);
      dec_valid = t.v; dec_opcode = t.op; dec_oprd1 = t.o1; dec_oprd2 = t.o2;
      mem_blocked = t.mb; alu_branch = t.br; alu_branch_rip = 64'h400100;
      #1;
      chk($sformatf("v%0d_en", i), alu_enable, t.e_en);
      chk($sformatf("v%0d_ready", i), dec_ready, t.e_rdy);
      chk($sformatf("v%0d_busy", i), busy, t.e_busy);
      chk($sformatf("v%0d_redirect", i), redirect, t.e_red);
      chk($sformatf("v%0d_flush", i), flush_dec, t.e_red);
      chk($sformatf("v%0d_oprd1", i), alu_oprd1, t.e_o1);
      chk($sformatf("v%0d_oprd2", i), alu_oprd2, t.e_o2);
      if (t.e_red) chk($sformatf("v%0d_rrip", i), redirect_rip, 64'h400100);
      if (t.v && t.e_rdy) tab_iss++;
      if (t.e_en && t.mb) tab_stall++;
    end
`ifdef EXE_PERF_EN
    chk("tab_perf_issued", perf_issued, tab_iss);
    chk("tab_perf_stall", perf_stall, tab_stall);
`endif

    // reset in the second IMUL cycle discards it without a redirect
    @(negedge clk);
    dec_valid = 1; dec_opcode = OPC_IMUL; dec_oprd1 = 77; mem_blocked = 0; alu_branch = 1;
    @(negedge clk); dec_valid = 0; #1;
    chk("r6_issue_en", alu_enable, 1);
    @(negedge clk); #1;
    chk("r6_multi_en", alu_enable, 1);
    chk("r6_multi_ready", dec_ready, 0);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("r6_en", alu_enable, 0);
    chk("r6_busy", busy, 0);
    chk("r6_ready", dec_ready, 0);
    chk("r6_redirect", redirect, 0);
    chk("r6_opcode", alu_opcode, 0);
    chk("r6_oprd1", alu_oprd1, 0);
`ifdef EXE_PERF_EN
    chk("r6_perf_issued", perf_issued, 0);
    chk("r6_perf_stall", perf_stall, 0);
`endif
    @(negedge clk); rst_n = 1'b1; #1;
    chk("r6_post_ready", dec_ready, 1);
    chk("r6_post_busy", busy, 0);
    @(negedge clk); #1;
    chk("r6_post_redirect", redirect, 0);
    chk("r6_post_flush", flush_dec, 0);

    // randomized traffic against the work-unit model (state is IDLE, hold regs 0)
    ops[0] = 10'h001; ops[1] = OPC_IMUL; ops[2] = 10'h0EB;
    ops[3] = 10'h070; ops[4] = 10'h180; ops[5] = 10'h2A3;
    m_have = 0; m_brw = 0; m_isbr = 0; m_left = 0;
    m_op = 0; m_o1 = 0; m_o2 = 0; m_o3 = 0; m_rip = 0;
    m_issued = 0; m_stall = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      dec_valid = ($urandom_range(0, 3) != 0);
      dec_opcode = ops[$urandom_range(0, 5)];
      if (dec_opcode == 10'h070 || dec_opcode == 10'h180 || dec_opcode == 10'h2A3)
        dec_opcode[3:0] = 4'($urandom_range(0, 15));
      dec_oprd1 = {$urandom, $urandom}; dec_oprd2 = {$urandom, $urandom};
      dec_oprd3 = {$urandom, $urandom}; dec_next_rip = {$urandom, $urandom};
      mem_blocked = ($urandom_range(0, 3) == 0);
      alu_branch = 1'($urandom_range(0, 1));
      alu_branch_rip = {$urandom, $urandom};
      #1;
      e_busy = m_have;
      e_en   = m_have && !m_brw;
      e_red  = m_have && m_brw && alu_branch;
      e_rdy  = !m_have || (!m_brw && !mem_blocked && m_left == 1 && !m_isbr);
      chk("rnd_en", alu_enable, e_en);
      chk("rnd_ready", dec_ready, e_rdy);
      chk("rnd_busy", busy, e_busy);
      chk("rnd_redirect", redirect, e_red);
      chk("rnd_flush", flush_dec, e_red);
      chk("rnd_opcode", alu_opcode, m_op);
      chk("rnd_oprd1", alu_oprd1, m_o1);
      chk("rnd_oprd2", alu_oprd2, m_o2);
      chk("rnd_oprd3", alu_oprd3, m_o3);
      chk("rnd_next_rip", alu_next_rip, m_rip);
      if (e_red) chk("rnd_rrip", redirect_rip, alu_branch_rip);
      xfer = dec_valid && e_rdy;
      if (xfer) m_issued++;
      if (e_en && mem_blocked) m_stall++;
      if (m_have && m_brw) begin
        m_have = 0;
      end else if (m_have && !mem_blocked) begin
        if (m_left == 1) begin
          if (m_isbr) m_brw = 1;
          else m_have = 0;
        end else begin
          m_left--;
        end
      end
      if (xfer) begin
        m_have = 1; m_brw = 0;
        m_left = (dec_opcode == OPC_IMUL) ? MUL_LAT : 1;
        m_isbr = ref_is_branch(dec_opcode);
        m_op = dec_opcode; m_o1 = dec_oprd1; m_o2 = dec_oprd2;
        m_o3 = dec_oprd3; m_rip = dec_next_rip;
      end
    end
`ifdef EXE_PERF_EN
    @(negedge clk); dec_valid = 0; mem_blocked = 0; #1;
    chk("rnd_perf_issued", perf_issued, m_issued);
    chk("rnd_perf_stall", perf_stall, m_stall);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
